// File: rtl/i2c_bus_driver.sv
// i2c_bus_driver: bit-level I2C master line driver executing START, STOP,
// WRITE and READ commands, with clock-stretch tolerant timing and
// arbitration-loss detection.
module i2c_bus_driver #(
    parameter int unsigned T_LOW    = 4,
    parameter int unsigned T_HIGH   = 4,
    parameter int unsigned T_SU_STA = 4,
    parameter int unsigned T_HD_STA = 4,
    parameter int unsigned T_SU_STO = 4,
    parameter int unsigned T_BUF    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] cmd,
    input  logic       cmd_vld,
    output logic       cmd_rdy,
    input  logic       din,
    output logic       dout,
    output logic       done,
    output logic       arb_lost,
    output logic       scl_o,
    output logic       sda_o,
    input  logic       scl_i,
    input  logic       sda_i
);

    localparam logic [1:0] CMD_START = 2'd0;
    localparam logic [1:0] CMD_STOP  = 2'd1;
    localparam logic [1:0] CMD_WRITE = 2'd2;
    localparam logic [1:0] CMD_READ  = 2'd3;

    localparam int unsigned T_M0  = (T_LOW > T_HIGH) ? T_LOW : T_HIGH;
    localparam int unsigned T_M1  = (T_SU_STA > T_HD_STA) ? T_SU_STA : T_HD_STA;
    localparam int unsigned T_M2  = (T_SU_STO > T_BUF) ? T_SU_STO : T_BUF;
    localparam int unsigned T_M3  = (T_M0 > T_M1) ? T_M0 : T_M1;
    localparam int unsigned T_MAX = (T_M2 > T_M3) ? T_M2 : T_M3;
    localparam int unsigned CW    = (T_MAX > 1) ? $clog2(T_MAX) : 1;

    typedef enum logic [3:0] {
        IDLE, RS_LO, SU_STA, HD_STA, BIT_LO, BIT_HI, STO_LO, SU_STO, BUF, DONE
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt, phase_last;
    logic [1:0]    cmd_q, cmd_q_nxt;
    logic          err_q, err_nxt;
    logic          own, own_nxt;
    logic          scl_nxt, sda_nxt, done_nxt, arb_nxt, dout_nxt;
    logic          cnt_run, cnt_end, sda_lost;

    // Last counter value of the current timed phase.
    always_comb begin
        phase_last = '0;
        case (state)
            RS_LO, BIT_LO, STO_LO: phase_last = CW'(T_LOW - 1);
            SU_STA:                phase_last = CW'(T_SU_STA - 1);
            HD_STA:                phase_last = CW'(T_HD_STA - 1);
            BIT_HI:                phase_last = CW'(T_HIGH - 1);
            SU_STO:                phase_last = CW'(T_SU_STO - 1);
            BUF:                   phase_last = CW'(T_BUF - 1);
            default:               phase_last = '0;
        endcase
    end

    // Counter only advances while the bus SCL matches what we drive (stretch freeze).
    assign cnt_run  = (scl_i == scl_o);
    assign cnt_end  = cnt_run && (cnt == phase_last);
    assign sda_lost = scl_i && sda_o && !sda_i;

    // Next-state, counter and output decode.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt_run ? cnt + CW'(1) : cnt;
        cmd_q_nxt = cmd_q;
        err_nxt   = err_q;
        own_nxt   = own;
        scl_nxt   = scl_o;
        sda_nxt   = sda_o;
        done_nxt  = 1'b0;
        arb_nxt   = 1'b0;
        dout_nxt  = dout;

        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (cmd_vld && cmd_rdy) begin
                    cmd_q_nxt = cmd;
                    err_nxt   = 1'b0;
                    case (cmd)
                        CMD_START: begin
                            if (own) begin
                                state_nxt = RS_LO;
                                sda_nxt   = 1'b1;
                            end else if (scl_i && sda_i) begin
                                state_nxt = SU_STA;
                                scl_nxt   = 1'b1;
                                sda_nxt   = 1'b1;
                            end else begin
                                state_nxt = DONE;
                                err_nxt   = 1'b1;
                            end
                        end
                        CMD_STOP: begin
                            if (own) begin
                                state_nxt = STO_LO;
                                sda_nxt   = 1'b0;
                            end else begin
                                state_nxt = DONE;
                                err_nxt   = 1'b1;
                            end
                        end
                        CMD_WRITE: begin
                            if (own) begin
                                state_nxt = BIT_LO;
                                sda_nxt   = din;
                            end else begin
                                state_nxt = DONE;
                                err_nxt   = 1'b1;
                            end
                        end
                        CMD_READ: begin
                            if (own) begin
                                state_nxt = BIT_LO;
                                sda_nxt   = 1'b1;
                            end else begin
                                state_nxt = DONE;
                                err_nxt   = 1'b1;
                            end
                        end
                        default: state_nxt = IDLE;
                    endcase
                end
            end
            RS_LO: begin
                if (cnt_end) begin
                    state_nxt = SU_STA;
                    cnt_nxt   = '0;
                    scl_nxt   = 1'b1;
                end
            end
            SU_STA: begin
                if (sda_lost) begin
                    state_nxt = DONE;
                    cnt_nxt   = '0;
                    scl_nxt   = 1'b1;
                    sda_nxt   = 1'b1;
                    err_nxt   = 1'b1;
                end else if (cnt_end) begin
                    state_nxt = HD_STA;
                    cnt_nxt   = '0;
                    sda_nxt   = 1'b0;
                end
            end
            HD_STA: begin
                if (cnt_end) begin
                    state_nxt = DONE;
                    cnt_nxt   = '0;
                    scl_nxt   = 1'b0;
                end
            end
            BIT_LO: begin
                if (cnt_end) begin
                    state_nxt = BIT_HI;
                    cnt_nxt   = '0;
                    scl_nxt   = 1'b1;
                end
            end
            BIT_HI: begin
                // A read bit legitimately sees SDA pulled low by the slave.
                if ((cmd_q != CMD_READ) && sda_lost) begin
                    state_nxt = DONE;
                    cnt_nxt   = '0;
                    scl_nxt   = 1'b1;
                    sda_nxt   = 1'b1;
                    err_nxt   = 1'b1;
                end else if (cnt_end) begin
                    state_nxt = DONE;
                    cnt_nxt   = '0;
                    scl_nxt   = 1'b0;
                    if (cmd_q == CMD_READ) begin
                        dout_nxt = sda_i;
                    end
                end
            end
            STO_LO: begin
                if (cnt_end) begin
                    state_nxt = SU_STO;
                    cnt_nxt   = '0;
                    scl_nxt   = 1'b1;
                end
            end
            SU_STO: begin
                if (cnt_end) begin
                    state_nxt = BUF;
                    cnt_nxt   = '0;
                    sda_nxt   = 1'b1;
                end
            end
            BUF: begin
                if (cnt_end) begin
                    state_nxt = DONE;
                    cnt_nxt   = '0;
                end
            end
            DONE: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
                done_nxt  = 1'b1;
                arb_nxt   = err_q;
                if (err_q) begin
                    own_nxt = 1'b0;
                end else if (cmd_q == CMD_START) begin
                    own_nxt = 1'b1;
                end else if (cmd_q == CMD_STOP) begin
                    own_nxt = 1'b0;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            cmd_q    <= CMD_START;
            err_q    <= 1'b0;
            own      <= 1'b0;
            scl_o    <= 1'b1;
            sda_o    <= 1'b1;
            done     <= 1'b0;
            arb_lost <= 1'b0;
            dout     <= 1'b0;
            cmd_rdy  <= 1'b1;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            cmd_q    <= cmd_q_nxt;
            err_q    <= err_nxt;
            own      <= own_nxt;
            scl_o    <= scl_nxt;
            sda_o    <= sda_nxt;
            done     <= done_nxt;
            arb_lost <= arb_nxt;
            dout     <= dout_nxt;
            cmd_rdy  <= (state_nxt == IDLE);
        end
    end

endmodule

// File: tb/tb_i2c_bus_driver.sv
// tb_i2c_bus_driver: directed and randomized commands against a phase-list
// reference model of the I2C line sequences, with an open-drain bus model
// that can stretch SCL and pull SDA low.
module tb_i2c_bus_driver;

    localparam int unsigned T_LOW    = 4;
    localparam int unsigned T_HIGH   = 4;
    localparam int unsigned T_SU_STA = 4;
    localparam int unsigned T_HD_STA = 4;
    localparam int unsigned T_SU_STO = 4;
    localparam int unsigned T_BUF    = 4;

    localparam logic [1:0] C_START = 2'd0;
    localparam logic [1:0] C_STOP  = 2'd1;
    localparam logic [1:0] C_WRITE = 2'd2;
    localparam logic [1:0] C_READ  = 2'd3;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] cmd;
    logic       cmd_vld;
    logic       cmd_rdy;
    logic       din;
    logic       dout;
    logic       done;
    logic       arb_lost;
    logic       scl_o, sda_o, scl_i, sda_i;

    logic sda_pull;
    int   stretch_n;
    int   hi_edges;

    int n_cmp;
    int n_mis;

    // Reference state of the bus owner as seen from outside.
    logic own_m, scl_m, sda_m, dout_m;

    int   ph_len[$];
    logic ph_scl[$];
    logic ph_sda[$];

    i2c_bus_driver #(
        .T_LOW(T_LOW), .T_HIGH(T_HIGH), .T_SU_STA(T_SU_STA),
        .T_HD_STA(T_HD_STA), .T_SU_STO(T_SU_STO), .T_BUF(T_BUF)
    ) dut (
        .clk(clk), .rst(rst), .cmd(cmd), .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy),
        .din(din), .dout(dout), .done(done), .arb_lost(arb_lost),
        .scl_o(scl_o), .sda_o(sda_o), .scl_i(scl_i), .sda_i(sda_i)
    );

    always #5 clk = ~clk;

    // Open-drain bus: a slave may hold SCL low for stretch_n cycles after each rise.
    assign scl_i = scl_o & (hi_edges >= stretch_n);
    assign sda_i = sda_o & ~sda_pull;

    always @(posedge clk) hi_edges <= scl_o ? hi_edges + 1 : 0;

    task automatic check_bit(input string tag, input logic got, input logic exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    function automatic string cname(input logic [1:0] c);
        case (c)
            C_START: return "START";
            C_STOP:  return "STOP";
            C_WRITE: return "WRITE";
            default: return "READ";
        endcase
    endfunction

    task automatic add_phase(input int len, input logic s, input logic d);
        ph_len.push_back(len);
        ph_scl.push_back(s);
        ph_sda.push_back(d);
    endtask

    // Issue one command and check every cycle until its done pulse.
    // pl: another agent pulls SDA low for the whole command; st: SCL stretch.
    task automatic run_cmd(input logic [1:0] c, input logic d, input logic pl, input int st);
        logic  exp_arb, own_after, dout_after;
        int    last;
        string nm;
        ph_len.delete();
        ph_scl.delete();
        ph_sda.delete();
        exp_arb    = 1'b0;
        own_after  = own_m;
        dout_after = dout_m;

        if ((!own_m && c != C_START) || (!own_m && c == C_START && pl)) begin
            // Rejected: lines untouched, done+arb_lost one cycle later.
            add_phase(1, scl_m, sda_m);
            exp_arb = 1'b1;
        end else if ((c == C_START || (c == C_WRITE && d)) && own_m && pl) begin
            // Lost arbitration on the first SCL-high cycle with SDA released.
            add_phase(T_LOW, 1'b0, 1'b1);
            add_phase(1, 1'b1, 1'b1);
            add_phase(1, 1'b1, 1'b1);
            exp_arb   = 1'b1;
            own_after = 1'b0;
        end else begin
            case (c)
                C_START: begin
                    if (own_m) begin
                        add_phase(T_LOW, 1'b0, 1'b1);
                        add_phase(T_SU_STA + st, 1'b1, 1'b1);
                    end else begin
                        add_phase(T_SU_STA, 1'b1, 1'b1);
                    end
                    add_phase(T_HD_STA, 1'b1, 1'b0);
                    add_phase(1, 1'b0, 1'b0);
                    own_after = 1'b1;
                end
                C_STOP: begin
                    add_phase(T_LOW, 1'b0, 1'b0);
                    add_phase(T_SU_STO + st, 1'b1, 1'b0);
                    add_phase(T_BUF, 1'b1, 1'b1);
                    add_phase(1, 1'b1, 1'b1);
                    own_after = 1'b0;
                end
                C_WRITE: begin
                    add_phase(T_LOW, 1'b0, d);
                    add_phase(T_HIGH + st, 1'b1, d);
                    add_phase(1, 1'b0, d);
                end
                default: begin
                    add_phase(T_LOW, 1'b0, 1'b1);
                    add_phase(T_HIGH + st, 1'b1, 1'b1);
                    add_phase(1, 1'b0, 1'b1);
                    dout_after = ~pl;
                end
            endcase
        end

        check_bit($sformatf("%s.rdy_before", cname(c)), cmd_rdy, 1'b1);
        cmd       = c;
        din       = d;
        cmd_vld   = 1'b1;
        sda_pull  = pl;
        stretch_n = st;
        @(negedge clk);
        for (int i = 0; i < ph_len.size(); i++) begin
            for (int j = 0; j < ph_len[i]; j++) begin
                nm = $sformatf("%s.p%0d.c%0d", cname(c), i, j);
                check_bit({nm, ".scl"}, scl_o, ph_scl[i]);
                check_bit({nm, ".sda"}, sda_o, ph_sda[i]);
                check_bit({nm, ".done"}, done, 1'b0);
                check_bit({nm, ".arb"}, arb_lost, 1'b0);
                check_bit({nm, ".rdy"}, cmd_rdy, 1'b0);
                // Commands offered while busy must be ignored.
                cmd_vld = 1'($urandom_range(0, 1));
                cmd     = 2'($urandom_range(0, 3));
                din     = 1'($urandom_range(0, 1));
                @(negedge clk);
            end
        end
        last = ph_len.size() - 1;
        nm = $sformatf("%s.end", cname(c));
        check_bit({nm, ".done"}, done, 1'b1);
        check_bit({nm, ".arb"}, arb_lost, exp_arb);
        check_bit({nm, ".rdy"}, cmd_rdy, 1'b1);
        check_bit({nm, ".scl"}, scl_o, ph_scl[last]);
        check_bit({nm, ".sda"}, sda_o, ph_sda[last]);
        check_bit({nm, ".dout"}, dout, dout_after);
        cmd_vld = 1'b0;
        own_m   = own_after;
        scl_m   = ph_scl[last];
        sda_m   = ph_sda[last];
        dout_m  = dout_after;
    endtask

    initial begin
        logic [1:0] c;
        logic       d, pl;
        int         st;
        n_cmp     = 0;
        n_mis     = 0;
        rst       = 1'b1;
        cmd       = C_START;
        cmd_vld   = 1'b0;
        din       = 1'b0;
        sda_pull  = 1'b0;
        stretch_n = 0;
        own_m     = 1'b0;
        scl_m     = 1'b1;
        sda_m     = 1'b1;
        dout_m    = 1'b0;
        repeat (3) @(negedge clk);
        check_bit("reset.scl", scl_o, 1'b1);
        check_bit("reset.sda", sda_o, 1'b1);
        check_bit("reset.done", done, 1'b0);
        check_bit("reset.arb", arb_lost, 1'b0);
        check_bit("reset.dout", dout, 1'b0);
        check_bit("reset.rdy", cmd_rdy, 1'b1);
        rst = 1'b0;
        @(negedge clk);

        // Illegal commands before owning the bus.
        run_cmd(C_WRITE, 1'b1, 1'b0, 0);
        run_cmd(C_STOP, 1'b0, 1'b0, 0);
        // START on idle bus, WRITE 1, READ with slave driving 0, READ of 1.
        run_cmd(C_START, 1'b0, 1'b0, 0);
        run_cmd(C_WRITE, 1'b1, 1'b0, 0);
        run_cmd(C_READ, 1'b0, 1'b1, 0);
        run_cmd(C_READ, 1'b0, 1'b0, 0);
        // Clock stretch of 10 cycles on a write bit.
        run_cmd(C_WRITE, 1'b0, 1'b0, 10);
        // Arbitration loss on WRITE 1, then the next WRITE is rejected.
        run_cmd(C_WRITE, 1'b1, 1'b1, 0);
        run_cmd(C_WRITE, 1'b1, 1'b0, 0);
        // START while SDA held low by another master.
        run_cmd(C_START, 1'b0, 1'b1, 0);
        // START, repeated START, STOP.
        run_cmd(C_START, 1'b0, 1'b0, 0);
        run_cmd(C_START, 1'b0, 1'b0, 0);
        run_cmd(C_STOP, 1'b0, 1'b0, 0);

        // Reset in the middle of a WRITE bit's SCL-high phase.
        run_cmd(C_START, 1'b0, 1'b0, 0);
        run_cmd(C_READ, 1'b0, 1'b0, 0);
        cmd       = C_WRITE;
        din       = 1'b1;
        cmd_vld   = 1'b1;
        sda_pull  = 1'b0;
        stretch_n = 0;
        @(negedge clk);
        cmd_vld = 1'b0;
        repeat (T_LOW + 1) @(negedge clk);
        check_bit("midrst.pre_scl", scl_o, 1'b1);
        check_bit("midrst.pre_dout", dout, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check_bit("midrst.scl", scl_o, 1'b1);
        check_bit("midrst.sda", sda_o, 1'b1);
        check_bit("midrst.rdy", cmd_rdy, 1'b1);
        check_bit("midrst.done", done, 1'b0);
        check_bit("midrst.arb", arb_lost, 1'b0);
        check_bit("midrst.dout", dout, 1'b0);
        rst    = 1'b0;
        own_m  = 1'b0;
        scl_m  = 1'b1;
        sda_m  = 1'b1;
        dout_m = 1'b0;
        @(negedge clk);
        run_cmd(C_STOP, 1'b0, 1'b0, 0);

        // Randomized command stream.
        for (int n = 0; n < 200; n++) begin
            if (!own_m && $urandom_range(0, 9) < 7) begin
                c = C_START;
            end else begin
                c = 2'($urandom_range(0, 3));
            end
            d  = 1'($urandom_range(0, 1));
            pl = ($urandom_range(0, 4) == 0);
            st = (own_m && !pl && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, 8)) : 0;
            run_cmd(c, d, pl, st);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/i2c_bus_driver.md
I2C_BUS_DRIVER -- requirements
Module: i2c_bus_driver

Interface
REQ-001 SHALL have parameter T_LOW, default 4: SCL low time in clk cycles (>=1).
REQ-002 SHALL have parameter T_HIGH, default 4: SCL high time in clk cycles (>=1).
REQ-003 SHALL have parameters T_SU_STA, T_HD_STA, T_SU_STO and T_BUF, each default 4: START setup, START hold, STOP setup and bus-free times in clk cycles (>=1).
REQ-004 SHALL have ports, clock and reset first:
- clk, in, 1: single clock.
- rst, in, 1: reset, synchronous, active-high.
- cmd, in, 2: 0=START, 1=STOP, 2=WRITE, 3=READ.
- cmd_vld, in, 1: command valid.
- cmd_rdy, out, 1: ready to accept a command.
- din, in, 1: bit to write, captured with WRITE.
- dout, out, 1: bit read.
- done, out, 1: one-cycle completion pulse.
- arb_lost, out, 1: one-cycle pulse, coincident with done, on arbitration loss or illegal command.
- scl_o, out, 1: 0 = pull SCL low, 1 = release.
- sda_o, out, 1: 0 = pull SDA low, 1 = release.
- scl_i, in, 1: synchronized SCL bus level.
- sda_i, in, 1: synchronized SDA bus level.

Function
REQ-005 SHALL accept a command when cmd_vld && cmd_rdy; cmd_rdy SHALL be 1 only in IDLE; cmd and din SHALL be captured on acceptance.
REQ-006 SHALL keep internal flag own: set on START completion; cleared on STOP completion, arb loss or reset.
REQ-007 All time counters SHALL run only while scl_i equals the SCL level the block is requesting; a released SCL held low by a slave (clock stretching) SHALL freeze the counter.
REQ-008 Counter width SHALL be sized to the maximum timing parameter.
REQ-009 START, own=0:
- if sda_i=0 or scl_i=0 at acceptance, pulse done+arb_lost the next cycle and leave the lines untouched;
- else: wait T_SU_STA with both lines released;
- then sda_o=0 for T_HD_STA;
- then scl_o=0, done.
REQ-010 START, own=1 (repeated START):
- SCL stays low;
- sda_o=1 for T_LOW;
- scl_o=1, then T_SU_STA high;
- continue as REQ-009 from the SDA-low phase.
REQ-011 WRITE, own=1:
- SCL low;
- sda_o=din for T_LOW;
- scl_o=1 for T_HIGH, then scl_o=0 with sda_o unchanged;
- done in the cycle following the SCL falling request.
REQ-012 READ SHALL be identical to WRITE with sda_o=1; dout SHALL be sda_i sampled in the last SCL-high cycle, held until the next READ completes.
REQ-013 Arbitration: during any SCL-high cycle in which sda_o=1 and sda_i=0 (WRITE/READ data phase, START setup phase), the block SHALL:
- release both lines the next cycle;
- pulse done+arb_lost;
- clear own;
- return to IDLE.
REQ-014 STOP, own=1:
- sda_o=0 with SCL low for T_LOW;
- scl_o=1, then T_SU_STO high;
- sda_o=1 for T_BUF;
- done, own=0.
REQ-015 WRITE, READ or STOP with own=0 SHALL pulse done+arb_lost the next cycle without touching the lines.
REQ-016 States SHALL be: IDLE, RS_LO, SU_STA, HD_STA, BIT_LO, BIT_HI, STO_LO, SU_STO, BUF, DONE; DONE lasts one cycle and returns to IDLE.
REQ-017 In IDLE, scl_o SHALL hold its last value (0 when own=1, 1 when own=0) and sda_o SHALL hold its last value.
REQ-018 cmd_vld asserted outside IDLE SHALL be ignored.

Reset
REQ-019 On rst=1 at a clk edge, the block SHALL set the following regardless of state, including mid-transfer: scl_o=1, sda_o=1, done=0, arb_lost=0, dout=0, own=0, cmd_rdy=1 on the next cycle, state IDLE.

Verification
REQ-020 START on an idle bus (defaults) -> sda_o falls 4 cycles after acceptance, scl_o falls 4 cycles later, done 1 cycle later, arb_lost=0.
REQ-021 WRITE din=1, then READ with sda_i=0 forced during SCL high -> each bit shows SCL low 4 / high 4 cycles; READ done with dout=0 and arb_lost=0.
REQ-022 WRITE din=1 with another master forcing sda_i=0 during SCL high -> lines released the next cycle, done+arb_lost pulse, the following WRITE is rejected with arb_lost.
REQ-023 Slave holds scl_i=0 for 10 cycles after scl_o=1 in a WRITE -> SCL-high phase extends to 10+4 cycles, bit otherwise unchanged.
REQ-024 Repeated START then STOP -> SDA rises while SCL is low, SDA falls while SCL is high, STOP ends with sda_o=1 after T_SU_STO, done after T_BUF, own=0.
REQ-025 rst asserted in the middle of BIT_HI of a WRITE -> next cycle scl_o=1, sda_o=1, cmd_rdy=1; a STOP issued afterwards returns arb_lost=1.
